// File: rtl/mem_ctrl_fsm.sv
// Memory controller sitting between the IF/MEM pipeline stages and a single
// byte-wide RAM port. Each request is split into little-endian byte accesses;
// read bytes are assembled into a word and handed back with a one-cycle done.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | RAM port quiet; accept MEM request first, else IF fetch
//   S_READ  | issue byte addresses, capture each byte one cycle later
//   S_WRITE | drive one byte per cycle with the write strobe high
//   S_DONE  | one-cycle done pulse to the owner; requests not sampled
module mem_ctrl_fsm #(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_done_o,
   output logic [31:0]   if_inst_o,
   input  logic          mem_req_i,
   input  logic          mem_we_i,
   input  logic [1:0]    mem_size_i,
   input  logic [AW-1:0] mem_addr_i,
   input  logic [31:0]   mem_wdata_i,
   output logic          mem_done_o,
   output logic [31:0]   mem_rdata_o,
   output logic          if_stall_req_o,
   output logic          mem_stall_req_o,
   input  logic [7:0]    ram_din_i,
   output logic [7:0]    ram_dout_o,
   output logic [AW-1:0] ram_addr_o,
   output logic          ram_wr_o
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          owner_mem_q, owner_mem_d;
   logic [AW-1:0] base_q, base_d;
   logic [2:0]    n_q, n_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   buf_q, buf_d;
   logic [31:0]   if_inst_q, if_inst_d;
   logic [31:0]   mem_rdata_q, mem_rdata_d;
   logic [2:0]    addr_off;

   // Next-state, datapath and RAM port decode; RAM outputs use registered state only.
   always_comb begin
      state_d     = state_q;
      owner_mem_d = owner_mem_q;
      base_d      = base_q;
      n_d         = n_q;
      cnt_d       = cnt_q;
      wdata_d     = wdata_q;
      buf_d       = buf_q;
      if_inst_d   = if_inst_q;
      mem_rdata_d = mem_rdata_q;
      addr_off    = 3'd0;
      ram_wr_o    = 1'b0;
      ram_dout_o  = 8'h00;
      ram_addr_o  = '0;
      if_done_o   = 1'b0;
      mem_done_o  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (mem_req_i) begin
               owner_mem_d = 1'b1;
               base_d      = mem_addr_i;
               wdata_d     = mem_wdata_i;
               cnt_d       = 3'd0;
               buf_d       = 32'h0;
               case (mem_size_i)
                  2'd0:    n_d = 3'd1;
                  2'd1:    n_d = 3'd2;
                  default: n_d = 3'd4;
               endcase
               state_d = mem_we_i ? S_WRITE : S_READ;
            end else if (if_req_i) begin
               owner_mem_d = 1'b0;
               base_d      = if_addr_i;
               n_d         = 3'd4;
               cnt_d       = 3'd0;
               buf_d       = 32'h0;
               state_d     = S_READ;
            end
         end
         S_WRITE: begin
            ram_wr_o   = 1'b1;
            ram_addr_o = base_q + AW'(cnt_q);
            case (cnt_q[1:0])
               2'd0: ram_dout_o = wdata_q[7:0];
               2'd1: ram_dout_o = wdata_q[15:8];
               2'd2: ram_dout_o = wdata_q[23:16];
               default: ram_dout_o = wdata_q[31:24];
            endcase
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == n_q - 3'd1) state_d = S_DONE;
         end
         S_READ: begin
            // The final cycle only collects the last byte, so the address stays put.
            addr_off   = (cnt_q < n_q) ? cnt_q : n_q - 3'd1;
            ram_addr_o = base_q + AW'(addr_off);
            case (cnt_q)
               3'd1: buf_d[7:0]   = ram_din_i;
               3'd2: buf_d[15:8]  = ram_din_i;
               3'd3: buf_d[23:16] = ram_din_i;
               3'd4: buf_d[31:24] = ram_din_i;
               default: ;
            endcase
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == n_q) begin
               state_d = S_DONE;
               if (owner_mem_q) mem_rdata_d = buf_d;
               else             if_inst_d   = buf_d;
            end
         end
         S_DONE: begin
            if_done_o  = ~owner_mem_q;
            mem_done_o = owner_mem_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign if_inst_o       = if_inst_q;
   assign mem_rdata_o     = mem_rdata_q;
   assign if_stall_req_o  = if_req_i & ~if_done_o;
   assign mem_stall_req_o = mem_req_i & ~mem_done_o;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         owner_mem_q <= 1'b0;
         base_q      <= '0;
         n_q         <= 3'd0;
         cnt_q       <= 3'd0;
         wdata_q     <= 32'h0;
         buf_q       <= 32'h0;
         if_inst_q   <= 32'h0;
         mem_rdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         owner_mem_q <= owner_mem_d;
         base_q      <= base_d;
         n_q         <= n_d;
         cnt_q       <= cnt_d;
         wdata_q     <= wdata_d;
         buf_q       <= buf_d;
         if_inst_q   <= if_inst_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Directed bench for mem_ctrl_fsm with a byte-wide RAM model (one-cycle read latency).
module tb_mem_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_done_o;
   logic [31:0] if_inst_o;
   logic        mem_req_i;
   logic        mem_we_i;
   logic [1:0]  mem_size_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic        mem_done_o;
   logic [31:0] mem_rdata_o;
   logic        if_stall_req_o;
   logic        mem_stall_req_o;
   logic [7:0]  ram_din_i;
   logic [7:0]  ram_dout_o;
   logic [31:0] ram_addr_o;
   logic        ram_wr_o;

   logic [7:0]  ram [logic [31:0]];
   logic        pl_we = 1'b0;
   logic [31:0] pl_addr = 32'h0;
   logic [7:0]  pl_data = 8'h0;

   int n_chk  = 0;
   int n_pass = 0;
   int wr_cnt;

   always #5 clk = ~clk;

   mem_ctrl_fsm #(.AW(32)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .if_done_o(if_done_o), .if_inst_o(if_inst_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
      .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
      .if_stall_req_o(if_stall_req_o), .mem_stall_req_o(mem_stall_req_o),
      .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o),
      .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o)
   );

   // RAM model: single writer process, preload port for the bench.
   always @(posedge clk) begin
      if (pl_we) ram[pl_addr] = pl_data;
      if (ram_wr_o) ram[ram_addr_o] = ram_dout_o;
      ram_din_i <= ram.exists(ram_addr_o) ? ram[ram_addr_o] : 8'h00;
   end

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : 8'h00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] d);
      pl_addr = a; pl_data = d; pl_we = 1'b1;
      tick();
      pl_we = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      if_req_i = 0; if_addr_i = 0;
      mem_req_i = 0; mem_we_i = 0; mem_size_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
      tick();
      preload(32'h100, 8'h13); preload(32'h101, 8'h05);
      preload(32'h102, 8'h10); preload(32'h103, 8'h00);
      preload(32'h40, 8'h80);  preload(32'h0, 8'h12);
      preload(32'hFFFF_FFFF, 8'h34);

      // reset state
      chk("rst_wr", ram_wr_o, 0);
      chk("rst_addr", ram_addr_o, 0);
      chk("rst_dout", ram_dout_o, 0);
      chk("rst_done", {if_done_o, mem_done_o}, 0);
      chk("rst_data", if_inst_o | mem_rdata_o, 0);
      rst = 1'b0;
      tick();

      // IF fetch at 0x100
      if_req_i = 1; if_addr_i = 32'h100;
      #1 chk("f_stall_A", if_stall_req_o, 1);
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k <= 4) chk($sformatf("f_addr%0d", k), ram_addr_o, 32'h100 + k - 1);
         chk($sformatf("f_done%0d", k), if_done_o, (k == 6));
         chk($sformatf("f_stall%0d", k), if_stall_req_o, (k < 6));
      end
      chk("f_inst", if_inst_o, 32'h0010_0513);
      if_req_i = 0;
      tick();
      chk("f_done_off", if_done_o, 0);
      chk("f_inst_hold", if_inst_o, 32'h0010_0513);

      // MEM store word at 0x20
      mem_req_i = 1; mem_we_i = 1; mem_size_i = 2; mem_addr_i = 32'h20; mem_wdata_i = 32'hDEAD_BEEF;
      wr_cnt = 0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (ram_wr_o) wr_cnt++;
         if (k <= 4) begin
            chk($sformatf("s_addr%0d", k), ram_addr_o, 32'h20 + k - 1);
            chk($sformatf("s_dout%0d", k), ram_dout_o, (32'hDEAD_BEEF >> (8 * (k - 1))) & 32'hFF);
         end
         chk($sformatf("s_done%0d", k), mem_done_o, (k == 5));
         if (k == 5) mem_req_i = 0;
      end
      chk("s_wr_cycles", wr_cnt, 4);
      chk("s_ram", {ram_rd(32'h23), ram_rd(32'h22), ram_rd(32'h21), ram_rd(32'h20)}, 32'hDEAD_BEEF);

      // simultaneous MEM load byte 0x40 and IF fetch 0x0; MEM wins
      mem_req_i = 1; mem_we_i = 0; mem_size_i = 0; mem_addr_i = 32'h40;
      if_req_i = 1; if_addr_i = 32'h0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k <= 4) chk($sformatf("a_mdone%0d", k), mem_done_o, (k == 3));
         chk($sformatf("a_idone%0d", k), if_done_o, (k == 10));
         if (k == 3) begin
            chk("a_rdata", mem_rdata_o, 32'h0000_0080);
            mem_req_i = 0;
         end
         if (k == 5) chk("a_if_addr", ram_addr_o, 32'h0);
      end
      chk("a_inst", if_inst_o, 32'h0000_0012);
      if_req_i = 0;

      // IF in flight, MEM load word 0x20 arrives at A+2 and waits
      tick();
      if_req_i = 1; if_addr_i = 32'h100;
      for (int k = 1; k <= 13; k++) begin
         tick();
         if (k == 2) begin
            mem_req_i = 1; mem_we_i = 0; mem_size_i = 2; mem_addr_i = 32'h20;
         end
         if (k <= 7) chk($sformatf("p_idone%0d", k), if_done_o, (k == 6));
         chk($sformatf("p_mdone%0d", k), mem_done_o, (k == 13));
         if (k == 3) chk("p_addr3", ram_addr_o, 32'h102);
         if (k == 6) begin
            chk("p_inst", if_inst_o, 32'h0010_0513);
            if_req_i = 0;
         end
         if (k == 8) chk("p_maddr", ram_addr_o, 32'h20);
      end
      chk("p_rdata", mem_rdata_o, 32'hDEAD_BEEF);
      mem_req_i = 0;

      // MEM load half wrapping across the top of the address space
      tick();
      mem_req_i = 1; mem_we_i = 0; mem_size_i = 1; mem_addr_i = 32'hFFFF_FFFF;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k == 1) chk("w_addr1", ram_addr_o, 32'hFFFF_FFFF);
         if (k == 2) chk("w_addr2", ram_addr_o, 32'h0);
         if (k == 3) chk("w_addr3", ram_addr_o, 32'h0);
         chk($sformatf("w_done%0d", k), mem_done_o, (k == 4));
      end
      chk("w_rdata", mem_rdata_o, 32'h0000_1234);
      mem_req_i = 0;

      // reset during a word store at A+2
      tick();
      mem_req_i = 1; mem_we_i = 1; mem_size_i = 2; mem_addr_i = 32'h60; mem_wdata_i = 32'hA1B2_C3D4;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("r_wr", ram_wr_o, 0);
      chk("r_done", mem_done_o, 0);
      chk("r_rdata_clr", mem_rdata_o, 0);
      chk("r_inst_clr", if_inst_o, 0);
      rst = 1'b0;
      mem_we_i = 0; mem_size_i = 0; mem_addr_i = 32'h40;
      for (int k = 4; k <= 6; k++) begin
         tick();
         if (k == 4) chk("r_new_addr", ram_addr_o, 32'h40);
         chk($sformatf("r_ndone%0d", k), mem_done_o, (k == 6));
      end
      chk("r_new_rdata", mem_rdata_o, 32'h0000_0080);
      mem_req_i = 0;
      chk("r_ram", {ram_rd(32'h63), ram_rd(32'h62), ram_rd(32'h61), ram_rd(32'h60)}, 32'h0000_C3D4);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
